idli_trace_m: RTL and testbench
===============================

# idli_trace_m

Retirement trace unit for the idli core. Samples execution-stage events on the 4-GCK sync counter and accumulates a per-instruction record: PC, register-write mask, predicate write, skip flag and optional timestamp. Each retired instruction's record is pushed into a parametrised FIFO, which a consumer drains through a valid/ready handshake. Successor to the single-instruction bench scoreboard: it is multi-entry, parametrised, and counts overflow.

## Interface
Parameters:
- DEPTH, 8, FIFO entries; a power of two, at least 2.
- NREGS, NUM_REGS (package), width of the register-write mask.
- TS_W, 16, timestamp width; used only with the macro.
- DROP_W, 8, width of the saturating dropped-record counter.

Ports:
- i_trc_gck  in  1  core clock; one clock domain.
- i_trc_rst  in  1  reset; synchronous, active-high.
- i_trc_ctr  in  ctr_t (2)  core sync counter, 0..3.
- i_trc_run  in  1  instruction running in EX.
- i_trc_skip  in  1  instruction is skipped (predicate false).
- i_trc_enc_vld  in  1  EX encoding valid.
- i_trc_enc_new  in  1  EX encoding is new.
- i_trc_pc  in  data_t (16)  current PC.
- i_trc_reg_wr  in  1  destination register write this instruction.
- i_trc_reg  in  $clog2(NREGS)  destination register index.
- i_trc_dst_p  in  1  destination is the predicate register.
- o_trc_vld  out  1  record available.
- i_trc_rdy  in  1  consumer accepts the record.
- o_trc_rec  out  trace_rec_t  head record.
- o_trc_count  out  $clog2(DEPTH+1)  occupancy.
- o_trc_ovf  out  1  sticky overflow flag.
- o_trc_drop  out  DROP_W  dropped-record count; saturates.
- i_trc_clr  in  1  clears o_trc_ovf and o_trc_drop.

## Operation
- Accumulators, updated only when i_trc_ctr == 0:
  - pc_acc <= i_trc_pc if enc_vld && enc_new.
  - mask_acc[i_trc_reg] <= 1 if reg_wr.
  - pwr_acc <= run && dst_p && !skip.
  - skip_acc <= run && skip.
- Retire event: i_trc_ctr == 3 && i_trc_run.
  - The record is built from the accumulators and pushed.
  - In the same cycle, mask_acc, pwr_acc and skip_acc clear to 0.
  - pc_acc holds its value.
- The FIFO uses wr/rd pointers of $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty. Pointers wrap modulo 2·DEPTH.
- Pop: o_trc_vld && i_trc_rdy.
- Push while full without a pop: the record is discarded, o_trc_ovf is set, and o_trc_drop increments, saturating at all-ones.
- Push and pop in the same cycle while full: both complete and occupancy stays DEPTH; nothing is dropped.
- Push and pop in the same cycle while empty: the push lands, the pop does not occur (o_trc_vld was 0), and count becomes 1.
- i_trc_clr in the same cycle as an overflow: clear wins. Flag and counter read 0 and that drop is not counted.
- Reset values: o_trc_vld 0, o_trc_count 0, o_trc_ovf 0, o_trc_drop 0, o_trc_rec 0. All accumulators, pointers and the timestamp reset to 0.
- Reset asserted mid-operation flushes all pending records; a partially accumulated instruction is lost.

## Timing
- Push to o_trc_vld: 1 cycle. The record is visible in the cycle after the ctr==3 retire.
- o_trc_rec is driven from a registered storage read of the head entry. It is stable while o_trc_vld && !i_trc_rdy.
- o_trc_count updates in the cycle after the push or pop.
- At most one push per 4 GCK cycles. The consumer may pop every cycle.

## Configuration
- IDLI_TRACE_TS_EN defined: adds a free-running TS_W counter.
  - The counter increments every GCK, wraps, and resets to 0.
  - Its value at the retire cycle is stored in trace_rec_t.ts.
- Not defined: the ts field and the counter are absent, and trace_rec_t holds only pc, mask, pwr and skip.

## Structure
- idli_pkg holds:
  - trace_rec_t: the packed record {pc data_t, mask [NUM_REGS-1:0], pwr, skip, and ts under the macro}.
  - TRACE_TS_W.
  - Reuses ctr_t, data_t and NUM_REGS.
- Sub-module idli_trace_fifo_m is the generic DEPTH-deep, valid/ready FIFO with count and push-drop indication. The top level contains the accumulators, the retire detection and the overflow counters.

## Test plan
- Single retire: pc 0x0040 new at ctr0, reg_wr r3, run, ctr=3 → next cycle o_trc_vld=1, rec.pc=0x0040, mask=0x0008, pwr=0, skip=0, count=1.
- Predicate write and skip: dst_p with skip=0 → rec.pwr=1. Next instruction with skip=1 → rec.skip=1, rec.pwr=0, mask=0.
- Fill and overflow: 10 retires with i_trc_rdy=0 and DEPTH=8 → count=8, o_trc_ovf=1, o_trc_drop=2. Drain → the 8 oldest PCs in order. i_trc_clr → ovf=0, drop=0.
- Full with simultaneous push and pop: full FIFO, i_trc_rdy=1 at the retire cycle → count stays 8, drop unchanged.
- Drop counter saturation: DROP_W=2 and 6 drops → o_trc_drop=3.
- Reset mid-fill: 3 records queued, i_trc_rst for one cycle → vld=0, count=0, the next retire yields count=1 with a fresh mask. Under IDLI_TRACE_TS_EN: ts equals the GCK count since the reset release.

Source files
------------

// File: rtl/idli_pkg.sv
// idli_pkg: shared core types and the retirement trace record (ts field under IDLI_TRACE_TS_EN).
package idli_pkg;
  localparam int NUM_REGS = 8;
  localparam int TRACE_TS_W = 16;
  typedef logic [1:0] ctr_t;
  typedef logic [15:0] data_t;
  typedef struct packed {
    data_t pc;
    logic [NUM_REGS-1:0] mask;
    logic pwr;
    logic skip;
`ifdef IDLI_TRACE_TS_EN
    logic [TRACE_TS_W-1:0] ts;
`endif
  } trace_rec_t;
endpackage

// File: rtl/idli_trace_fifo_m.sv
// idli_trace_fifo_m: DEPTH-deep valid/ready FIFO with registered head, count and push-drop flag.
module idli_trace_fifo_m #(
  parameter int DEPTH = 8,
  parameter int W = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         rdy,
  output logic         vld,
  output logic [W-1:0] dout,
  output logic [AW:0]  count,
  output logic         drop
);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp, rp_n;
  logic full, pop, wr;
  always_comb begin
    full = (wp ^ rp) == {1'b1, {AW{1'b0}}};
    vld = wp != rp;
    pop = vld && rdy;
    wr = push && (!full || pop);
    drop = push && full && !pop;
    count = wp - rp;
    rp_n = rp + {{AW{1'b0}}, pop};
  end
  always_ff @(posedge clk) if (wr) mem[wp[AW-1:0]] <= din;
  // head register bypasses the write when the new head is the slot being written
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      dout <= '0;
    end else begin
      wp <= wp + {{AW{1'b0}}, wr};
      rp <= rp_n;
      dout <= (wr && rp_n == wp) ? din : mem[rp_n[AW-1:0]];
    end
  end
endmodule

// File: rtl/idli_trace_m.sv
// idli_trace_m: retirement trace unit; accumulates per-instruction records into a FIFO.
// Define IDLI_TRACE_TS_EN to add a free-running timestamp to each record.
module idli_trace_m
  import idli_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int NREGS = NUM_REGS,
  parameter int TS_W = TRACE_TS_W,
  parameter int DROP_W = 8
) (
  input  logic                       i_trc_gck,
  input  logic                       i_trc_rst,
  input  ctr_t                       i_trc_ctr,
  input  logic                       i_trc_run,
  input  logic                       i_trc_skip,
  input  logic                       i_trc_enc_vld,
  input  logic                       i_trc_enc_new,
  input  data_t                      i_trc_pc,
  input  logic                       i_trc_reg_wr,
  input  logic [$clog2(NREGS)-1:0]   i_trc_reg,
  input  logic                       i_trc_dst_p,
  output logic                       o_trc_vld,
  input  logic                       i_trc_rdy,
  output trace_rec_t                 o_trc_rec,
  output logic [$clog2(DEPTH+1)-1:0] o_trc_count,
  output logic                       o_trc_ovf,
  output logic [DROP_W-1:0]          o_trc_drop,
  input  logic                       i_trc_clr
);
  data_t pc_acc;
  logic [NREGS-1:0] mask_acc;
  logic pwr_acc, skip_acc, retire, drop;
  trace_rec_t rec;
`ifdef IDLI_TRACE_TS_EN
  logic [TS_W-1:0] ts_q;
  always_ff @(posedge i_trc_gck) ts_q <= i_trc_rst ? '0 : ts_q + TS_W'(1);
`endif
  always_comb begin
    retire = i_trc_ctr == ctr_t'(3) && i_trc_run;
    rec = '0;
    rec.pc = pc_acc;
    rec.mask = mask_acc;
    rec.pwr = pwr_acc;
    rec.skip = skip_acc;
`ifdef IDLI_TRACE_TS_EN
    rec.ts = TRACE_TS_W'(ts_q);
`endif
  end
  // pc_acc deliberately survives retire so non-new encodings reuse the last PC
  always_ff @(posedge i_trc_gck) begin
    if (i_trc_rst) begin
      pc_acc <= '0;
      mask_acc <= '0;
      pwr_acc <= 1'b0;
      skip_acc <= 1'b0;
    end else if (i_trc_ctr == ctr_t'(0)) begin
      if (i_trc_enc_vld && i_trc_enc_new) pc_acc <= i_trc_pc;
      if (i_trc_reg_wr) mask_acc[i_trc_reg] <= 1'b1;
      pwr_acc <= i_trc_run && i_trc_dst_p && !i_trc_skip;
      skip_acc <= i_trc_run && i_trc_skip;
    end else if (retire) begin
      mask_acc <= '0;
      pwr_acc <= 1'b0;
      skip_acc <= 1'b0;
    end
  end
  always_ff @(posedge i_trc_gck) begin
    if (i_trc_rst || i_trc_clr) begin
      o_trc_ovf <= 1'b0;
      o_trc_drop <= '0;
    end else if (drop) begin
      o_trc_ovf <= 1'b1;
      o_trc_drop <= (&o_trc_drop) ? o_trc_drop : o_trc_drop + DROP_W'(1);
    end
  end
  idli_trace_fifo_m #(.DEPTH(DEPTH), .W($bits(trace_rec_t))) u_fifo (
    .clk(i_trc_gck),
    .rst(i_trc_rst),
    .push(retire),
    .din(rec),
    .rdy(i_trc_rdy),
    .vld(o_trc_vld),
    .dout(o_trc_rec),
    .count(o_trc_count),
    .drop(drop)
  );
endmodule

// File: tb/tb_idli_trace_m.sv
// tb_idli_trace_m: randomized scoreboard bench for idli_trace_m against a record-level model.
module tb_idli_trace_m;
  import idli_pkg::*;
  localparam int DEPTH = 8;
  localparam int DW = 3;
  logic clk = 0, rst = 1;
  ctr_t ctr;
  logic run, skip, enc_vld, enc_new, reg_wr, dst_p, rdy, clr;
  data_t pc;
  logic [2:0] rg;
  logic vld, ovf;
  trace_rec_t rec;
  logic [3:0] count;
  logic [DW-1:0] drop;
  int checks = 0, errors = 0;
  trace_rec_t m_q[$], pend_q[$];
  logic m_ovf, m_full, m_pop, clr3;
  int m_drop, tb_cyc, rdy_mode;
  data_t m_pc;
  logic [NUM_REGS-1:0] m_mask;
  trace_rec_t r;

  idli_trace_m #(.DEPTH(DEPTH), .DROP_W(DW)) dut (
    .i_trc_gck(clk), .i_trc_rst(rst), .i_trc_ctr(ctr), .i_trc_run(run),
    .i_trc_skip(skip), .i_trc_enc_vld(enc_vld), .i_trc_enc_new(enc_new),
    .i_trc_pc(pc), .i_trc_reg_wr(reg_wr), .i_trc_reg(rg), .i_trc_dst_p(dst_p),
    .o_trc_vld(vld), .i_trc_rdy(rdy), .o_trc_rec(rec), .o_trc_count(count),
    .o_trc_ovf(ovf), .o_trc_drop(drop), .i_trc_clr(clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tb_cyc <= rst ? 0 : tb_cyc + 1;

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, a, e);
    end
  endtask

  // monitor: compare DUT state to the model, then apply this cycle's pop/push/clr/reset
  always @(negedge clk) begin
    chk("vld", 64'(vld), 64'(m_q.size() != 0));
    chk("count", 64'(count), 64'(m_q.size()));
    chk("ovf", 64'(ovf), 64'(m_ovf));
    chk("drop", 64'(drop), 64'(m_drop));
    if (m_q.size() != 0) chk("rec", 64'(rec), 64'(m_q[0]));
    if (rst) begin
      m_q.delete();
      pend_q.delete();
      m_ovf = 0;
      m_drop = 0;
    end else begin
      m_full = m_q.size() == DEPTH;
      m_pop = m_q.size() != 0 && rdy;
      if (m_pop) void'(m_q.pop_front());
      if (pend_q.size() != 0) begin
        r = pend_q.pop_front();
        if (m_full && !m_pop) begin
          m_ovf = 1;
          if (m_drop < (1 << DW) - 1) m_drop++;
        end else m_q.push_back(r);
      end
      if (clr) begin
        m_ovf = 0;
        m_drop = 0;
      end
    end
  end

  function automatic logic rdy_val(int c);
    return rdy_mode == 1 ? 1'b1 : rdy_mode == 2 ? 1'($urandom_range(0, 1)) : rdy_mode == 3 ? (c == 3) : 1'b0;
  endfunction

  task automatic instr(data_t p, logic v, logic n, logic w, logic [2:0] ri, logic d, logic s, logic ru);
    trace_rec_t e;
    if (v && n) m_pc = p;
    if (w) m_mask[ri] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      ctr = ctr_t'(c); pc = p; enc_vld = v; enc_new = n; reg_wr = w; rg = ri;
      dst_p = d; skip = s; run = ru; clr = (c == 3) && clr3; rdy = rdy_val(c);
      if (c == 3 && ru) begin
        e = '0;
        e.pc = m_pc;
        e.mask = m_mask;
        e.pwr = d && !s;
        e.skip = s;
`ifdef IDLI_TRACE_TS_EN
        e.ts = TRACE_TS_W'(tb_cyc);
`endif
        pend_q.push_back(e);
        m_mask = '0;
      end
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      ctr = 2'd1; run = 0; clr = 0; rdy = rdy_val(0);
    end
  endtask

  task automatic rnd_instr();
    instr(data_t'($urandom), 1'b1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
          3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 5) != 0));
  endtask

  initial begin
    {ctr, run, skip, enc_vld, enc_new, reg_wr, dst_p, rdy, clr, pc, rg} = '0;
    rdy_mode = 0; clr3 = 0; m_mask = '0; m_pc = '0; m_ovf = 0; m_drop = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_rec", 64'(rec), 64'h0);
    instr(16'h0040, 1, 1, 1, 3'd3, 0, 0, 1);
    idle(1);
    @(negedge clk);
    chk("single_pc", 64'(rec.pc), 64'h40);
    chk("single_mask", 64'(rec.mask), 64'h08);
    chk("single_cnt", 64'(count), 64'd1);
    rdy_mode = 1;
    idle(3);
    instr(16'h0044, 1, 1, 0, 3'd0, 1, 0, 1);
    instr(16'h0048, 1, 1, 0, 3'd0, 1, 1, 1);
    idle(3);
    rdy_mode = 0;
    repeat (10) instr(data_t'($urandom), 1, 1, 1, 3'($urandom_range(0, 7)), 0, 0, 1);
    idle(2);
    @(negedge clk);
    chk("fill_cnt", 64'(count), 64'd8);
    chk("fill_ovf", 64'(ovf), 64'd1);
    chk("fill_drop", 64'(drop), 64'd2);
    rdy_mode = 3;
    instr(16'h1234, 1, 1, 1, 3'd1, 0, 0, 1);
    rdy_mode = 0;
    idle(2);
    @(negedge clk);
    chk("pp_cnt", 64'(count), 64'd8);
    chk("pp_drop", 64'(drop), 64'd2);
    rdy_mode = 1;
    idle(10);
    @(posedge clk); #1 clr = 1;
    @(posedge clk); #1 clr = 0;
    rdy_mode = 0;
    repeat (18) instr(data_t'($urandom), 1, 1, 0, 3'd0, 0, 0, 1);
    idle(1);
    @(negedge clk);
    chk("sat_drop", 64'(drop), 64'd7);
    clr3 = 1;
    instr(16'hbeef, 1, 1, 0, 3'd0, 0, 0, 1);
    clr3 = 0;
    idle(1);
    @(negedge clk);
    chk("clr_ovf", 64'(ovf), 64'd0);
    chk("clr_drop", 64'(drop), 64'd0);
    rdy_mode = 1;
    idle(10);
    rdy_mode = 2;
    for (int i = 0; i < 150; i++) begin
      clr3 = $urandom_range(0, 15) == 0;
      rnd_instr();
    end
    clr3 = 0;
    rdy_mode = 1;
    idle(10);
    rdy_mode = 0;
    repeat (3) instr(data_t'($urandom), 1, 1, 1, 3'd2, 0, 0, 1);
    instr(16'h7777, 1, 1, 1, 3'd4, 0, 0, 0);
    @(posedge clk); #1 rst = 1; run = 0; ctr = 2'd1;
    m_mask = '0; m_pc = '0;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("rst_vld", 64'(vld), 64'd0);
    chk("rst_cnt", 64'(count), 64'd0);
    instr(16'h0000, 0, 0, 1, 3'd5, 0, 0, 1);
    idle(1);
    @(negedge clk);
    chk("post_rst_cnt", 64'(count), 64'd1);
    chk("post_rst_mask", 64'(rec.mask), 64'h20);
    rdy_mode = 1;
    idle(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
